// File: rtl/vga_pkg.sv
// Shared types and default geometry for the VGA frame-buffer write path.
// Holds pixel format, packing factor, frame depth and the writer state enum.
package vga_pkg;

  localparam int unsigned PXL_WIDTH      = 1;
  localparam int unsigned PXL_PER_ROW    = 8;
  localparam int unsigned MEM_DEPTH      = 38400;
  localparam int unsigned MEM_ADDR_WIDTH = $clog2(MEM_DEPTH);
  localparam int unsigned DROP_CTR_WIDTH = 16;
  localparam int unsigned MEM_WIDTH      = PXL_PER_ROW * PXL_WIDTH;
  localparam int unsigned IDX_WIDTH      = (PXL_PER_ROW > 1) ? $clog2(PXL_PER_ROW) : 1;

  typedef logic [PXL_WIDTH-1:0] pixel_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

endpackage

// File: rtl/vga_pxl_packer.sv
// Packs consecutive pixels into one BRAM word, pixel k at bits [k*PXL_WIDTH +: PXL_WIDTH].
// Ports:
//   clk_i, rst_i   clock, async active-high reset
//   start_i        store pxl_i at slot 0 of a fresh word (frame start / restart)
//   load_i         store pxl_i at the current slot
//   flush_i        emit the partial word (unfilled slots are already zero)
//   pxl_i          pixel data
//   idx_o          slot the next pixel goes to
//   word_valid_o   registered one-cycle pulse: word_o just updated
//   word_o         last completed/flushed word, held until the next one
module vga_pxl_packer
  import vga_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 load_i,
  input  logic                 flush_i,
  input  pixel_t               pxl_i,
  output logic [IDX_WIDTH-1:0] idx_o,
  output logic                 word_valid_o,
  output logic [MEM_WIDTH-1:0] word_o
);

  logic [MEM_WIDTH-1:0] word_q;
  logic [MEM_WIDTH-1:0] word_ins_c;
  logic                 last_c;

  // Current partial word with the incoming pixel dropped into slot idx_o.
  always_comb begin
    word_ins_c = word_q;
    for (int unsigned k = 0; k < PXL_PER_ROW; k++) begin
      if (idx_o == IDX_WIDTH'(k)) word_ins_c[k*PXL_WIDTH +: PXL_WIDTH] = pxl_i;
    end
  end

  assign last_c = (idx_o == IDX_WIDTH'(PXL_PER_ROW - 1));

  // The working word is cleared whenever it is emitted, so unfilled slots stay zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_q       <= '0;
      idx_o        <= '0;
      word_valid_o <= 1'b0;
      word_o       <= '0;
    end else begin
      word_valid_o <= 1'b0;
      if (start_i) begin
        word_q <= MEM_WIDTH'(pxl_i);
        idx_o  <= IDX_WIDTH'(1);
      end else if (flush_i) begin
        word_o       <= word_q;
        word_valid_o <= 1'b1;
        word_q       <= '0;
        idx_o        <= '0;
      end else if (load_i) begin
        if (last_c) begin
          word_o       <= word_ins_c;
          word_valid_o <= 1'b1;
          word_q       <= '0;
          idx_o        <= '0;
        end else begin
          word_q <= word_ins_c;
          idx_o  <= idx_o + IDX_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: rtl/vga_frame_writer.sv
// Write-side stage of the frame buffer: accepts a pixel stream, packs words and
// writes them to BRAM port B in the same order the display side reads port A.
// Optional macro VGA_FRAME_WRITER_FLUSH_EN adds flush_i to emit a partial word.
// Ports:
//   clk_i, rst_i          clock, async active-high reset
//   en_i                  writer enable (pxl_ready_o follows it one cycle later)
//   pxl_i/pxl_valid_i     pixel stream, pxl_sof_i marks pixel 0 of a frame
//   pxl_ready_o           registered ready
//   mem_addr_o/data_o     BRAM port-B address and write data (held between writes)
//   mem_en_o/mem_we_o     one-cycle write strobe
//   frame_done_o          pulse with the write of the last frame word
//   sof_err_o             pulse after a SOF arrives mid-frame
//   drop_ctr_o            saturating count of pixels discarded while idle
//   flush_i               (VGA_FRAME_WRITER_FLUSH_EN only) write partial word now
module vga_frame_writer #(
  parameter int unsigned MEM_DEPTH      = vga_pkg::MEM_DEPTH,
  parameter int unsigned MEM_ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int unsigned DROP_CTR_WIDTH = vga_pkg::DROP_CTR_WIDTH
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_i,
  input  vga_pkg::pixel_t               pxl_i,
  input  logic                          pxl_valid_i,
  input  logic                          pxl_sof_i,
`ifdef VGA_FRAME_WRITER_FLUSH_EN
  input  logic                          flush_i,
`endif
  output logic                          pxl_ready_o,
  output logic [MEM_ADDR_WIDTH-1:0]     mem_addr_o,
  output logic [vga_pkg::MEM_WIDTH-1:0] mem_data_o,
  output logic                          mem_en_o,
  output logic                          mem_we_o,
  output logic                          frame_done_o,
  output logic                          sof_err_o,
  output logic [DROP_CTR_WIDTH-1:0]     drop_ctr_o
);

  import vga_pkg::*;

  state_t                    state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d, addr_inc_c;
  logic                      xfer_c, flush_c, last_pxl_c, last_addr_c;
  logic                      pk_start_c, pk_load_c, pk_flush_c;
  logic                      wr_c, done_c, sof_err_c, drop_inc_c;
  logic [IDX_WIDTH-1:0]      pk_idx;
  logic                      pk_word_valid;
  logic [MEM_WIDTH-1:0]      pk_word;

`ifdef VGA_FRAME_WRITER_FLUSH_EN
  assign flush_c = flush_i;
`else
  assign flush_c = 1'b0;
`endif

  assign xfer_c      = pxl_valid_i && pxl_ready_o;
  assign last_pxl_c  = (pk_idx == IDX_WIDTH'(PXL_PER_ROW - 1));
  assign last_addr_c = (addr_q == MEM_ADDR_WIDTH'(MEM_DEPTH - 1));
  assign addr_inc_c  = last_addr_c ? '0 : addr_q + MEM_ADDR_WIDTH'(1);

  vga_pxl_packer u_packer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (pk_start_c),
    .load_i       (pk_load_c),
    .flush_i      (pk_flush_c),
    .pxl_i        (pxl_i),
    .idx_o        (pk_idx),
    .word_valid_o (pk_word_valid),
    .word_o       (pk_word)
  );

  // Packer output is already registered and held, so it drives port B directly.
  assign mem_en_o   = pk_word_valid;
  assign mem_we_o   = pk_word_valid;
  assign mem_data_o = pk_word;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state, packer control and write decisions.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    pk_start_c = 1'b0;
    pk_load_c  = 1'b0;
    pk_flush_c = 1'b0;
    wr_c       = 1'b0;
    done_c     = 1'b0;
    sof_err_c  = 1'b0;
    drop_inc_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer_c) begin
          if (pxl_sof_i) begin
            pk_start_c = 1'b1;
            addr_d     = '0;
            state_d    = FILL;
          end else begin
            drop_inc_c = 1'b1;
          end
        end
      end
      FILL: begin
        if (flush_c && (pk_idx != '0)) begin
          // Flush wins; a pixel offered alongside it is counted as dropped.
          pk_flush_c = 1'b1;
          wr_c       = 1'b1;
          addr_d     = addr_inc_c;
          state_d    = IDLE;
          drop_inc_c = xfer_c;
        end else if (xfer_c) begin
          if (pxl_sof_i && !((pk_idx == '0) && (addr_q == '0))) begin
            pk_start_c = 1'b1;
            addr_d     = '0;
            sof_err_c  = 1'b1;
          end else begin
            pk_load_c = 1'b1;
            if (last_pxl_c) begin
              wr_c   = 1'b1;
              addr_d = addr_inc_c;
              if (last_addr_c) begin
                done_c  = 1'b1;
                state_d = IDLE;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Address counter, handshake and status registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pxl_ready_o  <= 1'b0;
      addr_q       <= '0;
      mem_addr_o   <= '0;
      frame_done_o <= 1'b0;
      sof_err_o    <= 1'b0;
      drop_ctr_o   <= '0;
    end else begin
      pxl_ready_o  <= en_i;
      addr_q       <= addr_d;
      frame_done_o <= done_c;
      sof_err_o    <= sof_err_c;
      if (wr_c) mem_addr_o <= addr_q;
      if (drop_inc_c && (drop_ctr_o != '1)) drop_ctr_o <= drop_ctr_o + DROP_CTR_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_vga_frame_writer.sv
// Directed bench for vga_frame_writer with a shrunk frame (16 words) and a
// 4-bit drop counter so the wrap and saturation boundaries are reachable.
module tb_vga_frame_writer;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 4;

  logic          clk = 1'b0;
  logic          rst_i, en_i, pxl_i, pxl_valid_i, pxl_sof_i;
`ifdef VGA_FRAME_WRITER_FLUSH_EN
  logic          flush_i;
`endif
  logic          pxl_ready_o, mem_en_o, mem_we_o, frame_done_o, sof_err_o;
  logic [AW-1:0] mem_addr_o;
  logic [7:0]    mem_data_o;
  logic [DW-1:0] drop_ctr_o;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  always #5 clk = ~clk;

  vga_frame_writer #(
    .MEM_DEPTH      (DEPTH),
    .MEM_ADDR_WIDTH (AW),
    .DROP_CTR_WIDTH (DW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .pxl_i        (pxl_i),
    .pxl_valid_i  (pxl_valid_i),
    .pxl_sof_i    (pxl_sof_i),
`ifdef VGA_FRAME_WRITER_FLUSH_EN
    .flush_i      (flush_i),
`endif
    .pxl_ready_o  (pxl_ready_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_en_o     (mem_en_o),
    .mem_we_o     (mem_we_o),
    .frame_done_o (frame_done_o),
    .sof_err_o    (sof_err_o),
    .drop_ctr_o   (drop_ctr_o)
  );

  always @(negedge clk) if (mem_we_o) wr_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic p, input logic s);
    pxl_valid_i = 1'b1;
    pxl_i       = p;
    pxl_sof_i   = s;
    step();
    pxl_valid_i = 1'b0;
    pxl_sof_i   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; en_i = 1'b0; pxl_i = 1'b0; pxl_valid_i = 1'b0; pxl_sof_i = 1'b0;
`ifdef VGA_FRAME_WRITER_FLUSH_EN
    flush_i = 1'b0;
`endif
    step(); step();
    chk("rst_ready", 32'(pxl_ready_o), 32'd0);
    chk("rst_we",    32'(mem_we_o),    32'd0);
    chk("rst_en",    32'(mem_en_o),    32'd0);
    chk("rst_addr",  32'(mem_addr_o),  32'd0);
    chk("rst_data",  32'(mem_data_o),  32'd0);
    chk("rst_done",  32'(frame_done_o),32'd0);
    chk("rst_soferr",32'(sof_err_o),   32'd0);
    chk("rst_drop",  32'(drop_ctr_o),  32'd0);
    en_i = 1'b1;
    step();
    chk("ready_in_rst", 32'(pxl_ready_o), 32'd0);
    rst_i = 1'b0;
    step();
    chk("ready_after_rst", 32'(pxl_ready_o), 32'd1);

    // Pixels without SOF while idle are dropped; counter saturates.
    repeat (5) push(1'b1, 1'b0);
    chk("drop_5", 32'(drop_ctr_o), 32'd5);
    repeat (19) push(1'b0, 1'b0);
    chk("drop_sat", 32'(drop_ctr_o), 32'hF);
    chk("drop_no_writes", 32'(wr_cnt), 32'd0);

    // First word: 1,0,1,1,0,0,0,1 -> 8'h8D at address 0.
    push(1'b1, 1'b1); push(1'b0, 1'b0); push(1'b1, 1'b0); push(1'b1, 1'b0);
    push(1'b0, 1'b0); push(1'b0, 1'b0); push(1'b0, 1'b0);
    chk("w0_we_early", 32'(mem_we_o), 32'd0);
    push(1'b1, 1'b0);
    chk("w0_we",   32'(mem_we_o),     32'd1);
    chk("w0_en",   32'(mem_en_o),     32'd1);
    chk("w0_addr", 32'(mem_addr_o),   32'd0);
    chk("w0_data", 32'(mem_data_o),   32'h8D);
    chk("w0_done", 32'(frame_done_o), 32'd0);
    step();
    chk("w0_we_off",    32'(mem_we_o),   32'd0);
    chk("w0_data_hold", 32'(mem_data_o), 32'h8D);
    chk("w0_addr_hold", 32'(mem_addr_o), 32'd0);

    // Word 1: alternating 0,1 -> 8'hAA at address 1.
    for (int i = 0; i < 8; i++) push(1'(i), 1'b0);
    chk("w1_addr", 32'(mem_addr_o), 32'd1);
    chk("w1_data", 32'(mem_data_o), 32'hAA);

    // Three pixels of word 2, then a mid-frame SOF restarts at address 0.
    repeat (3) push(1'b1, 1'b0);
    push(1'b1, 1'b1);
    chk("midsof_err",  32'(sof_err_o), 32'd1);
    chk("midsof_nowr", 32'(mem_we_o),  32'd0);
    push(1'b0, 1'b0);
    chk("midsof_err_off", 32'(sof_err_o), 32'd0);
    push(1'b1, 1'b0); push(1'b0, 1'b0);

    // en_i low pauses mid-word; offered pixels are not consumed.
    en_i = 1'b0;
    step();
    chk("pause_ready", 32'(pxl_ready_o), 32'd0);
    pxl_valid_i = 1'b1; pxl_i = 1'b1;
    step(); step(); step();
    pxl_valid_i = 1'b0; en_i = 1'b1;
    step();
    chk("resume_ready", 32'(pxl_ready_o), 32'd1);
    push(1'b1, 1'b0); push(1'b0, 1'b0); push(1'b1, 1'b0); push(1'b0, 1'b0);
    chk("restart_we",   32'(mem_we_o),   32'd1);
    chk("restart_addr", 32'(mem_addr_o), 32'd0);
    chk("restart_data", 32'(mem_data_o), 32'h55);

    // A write completing in the cycle before a SOF still lands.
    repeat (8) push(1'b1, 1'b0);
    chk("pend_we",   32'(mem_we_o),   32'd1);
    chk("pend_addr", 32'(mem_addr_o), 32'd1);
    chk("pend_data", 32'(mem_data_o), 32'hFF);
    push(1'b1, 1'b1);
    chk("pend_soferr", 32'(sof_err_o), 32'd1);
    chk("pend_nowr",   32'(mem_we_o),  32'd0);

    // Asynchronous reset at pixel 5 clears everything without a clock edge.
    repeat (4) push(1'b1, 1'b0);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_ready", 32'(pxl_ready_o), 32'd0);
    chk("arst_we",    32'(mem_we_o),    32'd0);
    chk("arst_addr",  32'(mem_addr_o),  32'd0);
    chk("arst_data",  32'(mem_data_o),  32'd0);
    chk("arst_drop",  32'(drop_ctr_o),  32'd0);
    step();
    rst_i = 1'b0;
    step();
    push(1'b1, 1'b1);
    repeat (7) push(1'b0, 1'b0);
    chk("clean_we",   32'(mem_we_o),   32'd1);
    chk("clean_addr", 32'(mem_addr_o), 32'd0);
    chk("clean_data", 32'(mem_data_o), 32'h01);

    // Remaining words of the frame; frame_done only with the last address.
    for (int w = 1; w < 16; w++) begin
      for (int i = 0; i < 8; i++) push(1'(i), 1'b0);
      chk("frame_addr", 32'(mem_addr_o),   32'(w));
      chk("frame_we",   32'(mem_we_o),     32'd1);
      chk("frame_done", 32'(frame_done_o), (w == 15) ? 32'd1 : 32'd0);
    end

    // SOF in the frame_done cycle starts a new frame at wrapped address 0.
    push(1'b1, 1'b1);
    chk("wrap_soferr",   32'(sof_err_o),    32'd0);
    chk("wrap_done_off", 32'(frame_done_o), 32'd0);
    repeat (7) push(1'b0, 1'b0);
    chk("wrap_addr", 32'(mem_addr_o), 32'd0);
    chk("wrap_data", 32'(mem_data_o), 32'h01);

`ifdef VGA_FRAME_WRITER_FLUSH_EN
    // Flush of a 3-pixel partial word at address 1, then idle.
    repeat (3) push(1'b1, 1'b0);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("flush_we",   32'(mem_we_o),     32'd1);
    chk("flush_addr", 32'(mem_addr_o),   32'd1);
    chk("flush_data", 32'(mem_data_o),   32'h07);
    chk("flush_done", 32'(frame_done_o), 32'd0);
    push(1'b1, 1'b0);
    chk("flush_idle_drop", 32'(drop_ctr_o), 32'd1);
`endif

    step();
`ifdef VGA_FRAME_WRITER_FLUSH_EN
    chk("write_count", 32'(wr_cnt), 32'd22);
`else
    chk("write_count", 32'(wr_cnt), 32'd21);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
